// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI serial-clock generator.
// FSM encoding, SPI mode codes and default widths.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  // {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int DIV_W_DEF = 8;
  localparam int LEN_W_DEF = 6;

  // Modes 0 and 2 sample on the leading edge, modes 1 and 3 shift on it.
  function automatic logic samp_lead(input logic [1:0] mode);
    return (mode == MODE0) || (mode == MODE2);
  endfunction

endpackage

// File: rtl/spi_half_period_cnt.sv
// Half-period counter: counts 0..term_i, pulses wrap_o on the terminal
// count and restarts from zero. Shared by the clocking and hold phases.
module spi_half_period_cnt #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] term_i,
  output logic             wrap_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == term_i);

  // Next count: clear wins, otherwise advance or wrap when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_clk_gen.sv
// SPI master serial-clock generator with divider, CPOL/CPHA modes,
// frame-length edge counting and chip-select abort.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             m_clk,
  input  logic             nrst,
  input  logic             spi_cs,
  input  logic             start,
  input  logic [DIV_W-1:0] div,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             cpol,
  input  logic             cpha,
  output logic             spi_clk,
  output logic             sample_stb,
  output logic             shift_stb,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_l_q, div_l_d;
  logic [LEN_W-1:0] len_l_q, len_l_d;
  logic             cpol_l_q, cpol_l_d;
  logic             cpha_l_q, cpha_l_d;
  logic [LEN_W:0]   edge_q, edge_d;
  logic             clk_q, clk_d;
  logic             smp_q, smp_d;
  logic             shf_q, shf_d;
  logic             done_q, done_d;
  logic             settle_q, settle_d;
  logic             cnt_clr, cnt_en, wrap;

  spi_half_period_cnt #(
    .DIV_W (DIV_W)
  ) u_hp_cnt (
    .clk_i  (m_clk),
    .rst_ni (nrst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .term_i (div_l_q),
    .wrap_o (wrap)
  );

  // Next-state, edge generation and strobe decode.
  always_comb begin
    state_d  = state_q;
    div_l_d  = div_l_q;
    len_l_d  = len_l_q;
    cpol_l_d = cpol_l_q;
    cpha_l_d = cpha_l_q;
    edge_d   = edge_q;
    clk_d    = clk_q;
    smp_d    = 1'b0;
    shf_d    = 1'b0;
    done_d   = 1'b0;
    settle_d = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        clk_d   = cpol;
        cnt_clr = 1'b1;
        if (start && !spi_cs) begin
          div_l_d  = div;
          len_l_d  = frame_len;
          cpol_l_d = cpol;
          cpha_l_d = cpha;
          edge_d   = '0;
          state_d  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (spi_cs) begin
          state_d = IDLE;
          clk_d   = cpol;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
          if (wrap) begin
            if (len_l_q == '0) begin
              state_d  = HOLD;
              settle_d = 1'b1;
            end else begin
              edge_d = edge_q + 1'b1;
              clk_d  = ~clk_q;
              smp_d  = (edge_d[0] ==
                        samp_lead({cpol_l_q, cpha_l_q}));
              shf_d  = ~smp_d;
              if (edge_d == {len_l_q, 1'b0}) begin
                state_d  = HOLD;
                settle_d = 1'b1;
              end
            end
          end
        end
      end
      HOLD: begin
        if (spi_cs) begin
          state_d = IDLE;
          clk_d   = cpol;
          cnt_clr = 1'b1;
        end else begin
          // One settle cycle after the last edge, then a half-period.
          cnt_en = ~settle_q;
          if (wrap) begin
            state_d = IDLE;
            done_d  = 1'b1;
            clk_d   = cpol_l_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched frame parameters and registered outputs.
  always_ff @(posedge m_clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      div_l_q  <= '0;
      len_l_q  <= '0;
      cpol_l_q <= 1'b0;
      cpha_l_q <= 1'b0;
      edge_q   <= '0;
      clk_q    <= 1'b0;
      smp_q    <= 1'b0;
      shf_q    <= 1'b0;
      done_q   <= 1'b0;
      settle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_l_q  <= div_l_d;
      len_l_q  <= len_l_d;
      cpol_l_q <= cpol_l_d;
      cpha_l_q <= cpha_l_d;
      edge_q   <= edge_d;
      clk_q    <= clk_d;
      smp_q    <= smp_d;
      shf_q    <= shf_d;
      done_q   <= done_d;
      settle_q <= settle_d;
    end
  end

  assign spi_clk    = clk_q;
  assign sample_stb = smp_q;
  assign shift_stb  = shf_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);

endmodule
